hack_data_mem: RTL and testbench

- Data-side responder for the Hack CPU core's data bus: it serves `data_addr`/`wdata`/`we` and returns `rdata`.
- Contains a synchronous data RAM and a small memory-mapped I/O page for the board's switches, key, LEDs and hex displays.
- Sits between the CPU core and the board pins in the top level.

---
 rtl/hack_data_mem.sv | 249 ++++++++++++++++++++++++
 tb/tb_hack_data_mem.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : hack_data_mem
// Description : Data-side responder for the Hack CPU data bus. Holds the
//               synchronous data RAM and a small memory-mapped I/O page for
//               the board switches, push key, LEDs and hex displays.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Address map (15-bit word addresses):
//   0x0000..RAM_WORDS-1 : RAM, read/write
//   0x4000              : LED register (LED_WIDTH bits, upper bits read 0)
//   0x4001              : HEX register (16 bits)
//   0x6000              : switch status, read-only {0, sw_sync}
//   0x6001              : key status, read-only {0, pressed_level, event_flag}
//   anything else       : reads 0, writes ignored, bad_addr pulse on we|re
// ----------------------------------------------------------------------------
// Ports:
//   CPUclk    in   system clock, rising edge
//   nrst      in   asynchronous active-low reset
//   data_addr in   15-bit word address
//   wdata     in   16-bit write data
//   we        in   write strobe
//   re        in   read strobe (qualifies read side effects and bad_addr)
//   rdata     out  read data, one cycle after the address is sampled
//   sw        in   raw slide switches (asynchronous)
//   key_n     in   raw push button, low = pressed (asynchronous)
//   ledr      out  LED register
//   hex_val   out  HEX register
//   bad_addr  out  one-cycle pulse on an access to an unmapped address
//   hex0..3   out  (HACK_HEX_DECODE_EN only) registered active-low
//                  seven-segment decodes of hex_val nibbles, bit7 = dp (off)
// ----------------------------------------------------------------------------
// Build option: define HACK_HEX_DECODE_EN to add the hex0..hex3 decoders.
// ============================================================================
module hack_data_mem #(
  parameter int RAM_WORDS = 16384,
  parameter int SW_WIDTH  = 10,
  parameter int LED_WIDTH = 10
) (
  input  logic                 CPUclk,
  input  logic                 nrst,
  input  logic [14:0]          data_addr,
  input  logic [15:0]          wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [15:0]          rdata,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic                 key_n,
  output logic [LED_WIDTH-1:0] ledr,
  output logic [15:0]          hex_val,
  output logic                 bad_addr
`ifdef HACK_HEX_DECODE_EN
  ,
  output logic [7:0]           hex0,
  output logic [7:0]           hex1,
  output logic [7:0]           hex2,
  output logic [7:0]           hex3
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [15:0] c_RAM_LIMIT = 16'(RAM_WORDS);
  localparam logic [14:0] c_ADDR_LED  = 15'h4000;
  localparam logic [14:0] c_ADDR_HEX  = 15'h4001;
  localparam logic [14:0] c_ADDR_SW   = 15'h6000;
  localparam logic [14:0] c_ADDR_KEY  = 15'h6001;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                w_sel_ram;
  logic                w_sel_led;
  logic                w_sel_hex;
  logic                w_sel_sw;
  logic                w_sel_key;
  logic                w_mapped;
  logic [c_RAM_AW-1:0] w_ram_idx;

  assign w_sel_ram = ({1'b0, data_addr} < c_RAM_LIMIT);
  assign w_sel_led = (data_addr == c_ADDR_LED);
  assign w_sel_hex = (data_addr == c_ADDR_HEX);
  assign w_sel_sw  = (data_addr == c_ADDR_SW);
  assign w_sel_key = (data_addr == c_ADDR_KEY);
  assign w_mapped  = w_sel_ram | w_sel_led | w_sel_hex | w_sel_sw | w_sel_key;
  // Only the low address bits index the array; w_sel_ram gates the access.
  assign w_ram_idx = data_addr[c_RAM_AW-1:0];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;
  logic                 r_key_meta;
  logic                 r_key_sync;
  logic                 r_key_prev;
  logic                 r_key_flag;
  logic [LED_WIDTH-1:0] r_led;
  logic [15:0]          r_hex;
  logic [15:0]          r_io_q;
  logic                 r_rsel_ram;
  logic                 r_bad;

  logic [15:0]          r_ram_q;
  logic [15:0]          r_mem [RAM_WORDS];

  // --------------------------------------------------------------------------
  // Key event logic
  // --------------------------------------------------------------------------
  logic w_key_press;
  logic w_key_clr;
  logic w_key_flag_nxt;
  logic w_key_level;

  // Press = synchronized key_n falling from released (1) to pressed (0).
  assign w_key_press    = r_key_prev & ~r_key_sync;
  assign w_key_clr      = re & w_sel_key;
  // A press in the same cycle as a clearing read keeps the flag set.
  assign w_key_flag_nxt = w_key_press | (r_key_flag & ~w_key_clr);
  assign w_key_level    = ~r_key_sync;

  // --------------------------------------------------------------------------
  // I/O read mux (uses pre-edge register values, so read-during-write
  // returns the old contents)
  // --------------------------------------------------------------------------
  logic [15:0] w_io_rd;

  always_comb begin
    w_io_rd = '0;
    if (w_sel_led) begin
      w_io_rd = 16'(r_led);
    end else if (w_sel_hex) begin
      w_io_rd = r_hex;
    end else if (w_sel_sw) begin
      w_io_rd = 16'(r_sw_sync);
    end else if (w_sel_key) begin
      w_io_rd = {14'd0, w_key_level, r_key_flag};
    end
  end

  // --------------------------------------------------------------------------
  // Data RAM: read-before-write, no reset on the array or its read register.
  // The output select below forces rdata to zero until a RAM read is done.
  // --------------------------------------------------------------------------
  always_ff @(posedge CPUclk) begin
    r_ram_q <= r_mem[w_ram_idx];
    if (we && w_sel_ram) begin
      r_mem[w_ram_idx] <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Control / I/O registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CPUclk or negedge nrst) begin
    if (!nrst) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
      r_key_prev <= 1'b1;
      r_key_flag <= 1'b0;
      r_led      <= '0;
      r_hex      <= '0;
      r_io_q     <= '0;
      r_rsel_ram <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      // Two-flop synchronizers on the asynchronous board inputs
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= key_n;
      r_key_sync <= r_key_meta;
      r_key_prev <= r_key_sync;

      r_key_flag <= w_key_flag_nxt;

      if (we && w_sel_led) begin
        r_led <= LED_WIDTH'(wdata);
      end
      if (we && w_sel_hex) begin
        r_hex <= wdata;
      end

      // Read data path updates every cycle regardless of re
      r_io_q     <= w_io_rd;
      r_rsel_ram <= w_sel_ram;

      r_bad      <= (we | re) & ~w_mapped;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rdata    = r_rsel_ram ? r_ram_q : r_io_q;
  assign ledr     = r_led;
  assign hex_val  = r_hex;
  assign bad_addr = r_bad;

`ifdef HACK_HEX_DECODE_EN
  // --------------------------------------------------------------------------
  // Seven-segment decoders: active-low {dp, g, f, e, d, c, b, a}, dp held off
  // --------------------------------------------------------------------------
  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [7:0] r_seg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_seg
    always_ff @(posedge CPUclk or negedge nrst) begin
      if (!nrst) begin
        r_seg[gi] <= 8'hFF;
      end else begin
        r_seg[gi] <= seg7(r_hex[gi*4 +: 4]);
      end
    end
  end

  assign hex0 = r_seg[0];
  assign hex1 = r_seg[1];
  assign hex2 = r_seg[2];
  assign hex3 = r_seg[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_data_mem
// Description : Self-checking bench for hack_data_mem: directed vector table,
//               hand-written multi-cycle sequences (synchronizer latency, key
//               event set/clear race, asynchronous reset), then randomized
//               traffic checked against a behavioural memory-map model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_data_mem;

  localparam int          RAM_WORDS = 16384;
  localparam logic [15:0] c_LED_MASK = 16'h03FF;

  logic        CPUclk;
  logic        nrst;
  logic [14:0] data_addr;
  logic [15:0] wdata;
  logic        we;
  logic        re;
  logic [15:0] rdata;
  logic [9:0]  sw;
  logic        key_n;
  logic [9:0]  ledr;
  logic [15:0] hex_val;
  logic        bad_addr;
`ifdef HACK_HEX_DECODE_EN
  logic [7:0]  hex0, hex1, hex2, hex3;
`endif

  int checks = 0;
  int errors = 0;

  hack_data_mem #(
    .RAM_WORDS (RAM_WORDS),
    .SW_WIDTH  (10),
    .LED_WIDTH (10)
  ) dut (
    .CPUclk    (CPUclk),
    .nrst      (nrst),
    .data_addr (data_addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .rdata     (rdata),
    .sw        (sw),
    .key_n     (key_n),
    .ledr      (ledr),
    .hex_val   (hex_val),
    .bad_addr  (bad_addr)
`ifdef HACK_HEX_DECODE_EN
    ,
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3)
`endif
  );

  initial CPUclk = 1'b0;
  always #5 CPUclk = ~CPUclk;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle away from it
  task automatic tick();
    @(posedge CPUclk);
    #1;
  endtask

  task automatic drive(input logic [14:0] a, input logic [15:0] d, input logic w, input logic r);
    data_addr = a;
    wdata     = d;
    we        = w;
    re        = r;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_rdata", rdata, 16'h0);
    check("reset_ledr", 16'(ledr), 16'h0);
    check("reset_hex", hex_val, 16'h0);
    check("reset_bad", 16'(bad_addr), 16'h0);
    nrst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_bad;
    logic [9:0]  exp_led;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t vecs[18];

  // --------------------------------------------------------------------------
  // Behavioural reference model for the random phase
  // --------------------------------------------------------------------------
  logic [15:0] m_mem [int];
  logic [15:0] m_led;
  logic [15:0] m_hex;
  logic        m_flag;
  logic        key_hist[$];   // [0] = pin at current edge, [n] = n edges earlier
  logic [9:0]  sw_hist[$];

  function automatic logic is_mapped(input logic [14:0] a);
    return (int'(a) < RAM_WORDS) || a == 15'h4000 || a == 15'h4001 ||
           a == 15'h6000 || a == 15'h6001;
  endfunction

  task automatic model_reset();
    m_led  = 16'h0;
    m_hex  = 16'h0;
    m_flag = 1'b0;
    key_hist = '{1'b1, 1'b1, 1'b1};
    sw_hist  = '{10'h0, 10'h0, 10'h0};
  endtask

  task automatic random_cycle();
    logic [14:0] a;
    logic [15:0] d;
    logic        w, r;
    logic [15:0] exp_rd;
    logic        rd_known;
    logic        exp_bad;
    logic        synced_key, prev_key;

    case ($urandom_range(0, 9))
      0, 1:    a = 15'($urandom_range(0, 15));
      2:       a = 15'($urandom_range(16'h3FF0, 16'h3FFF));
      3:       a = 15'h4000;
      4:       a = 15'h4001;
      5:       a = 15'h6000;
      6:       a = 15'h6001;
      7:       a = 15'($urandom_range(16'h4002, 16'h5FFF));
      8:       a = 15'($urandom_range(16'h6002, 16'h7FFF));
      default: a = 15'($urandom_range(0, 3));
    endcase
    d = 16'($urandom);
    w = ($urandom_range(0, 2) == 0);
    r = ($urandom_range(0, 1) == 0);
    if ($urandom_range(0, 7) == 0) key_n = ~key_n;
    if ($urandom_range(0, 3) == 0) sw = 10'($urandom);

    key_hist.push_front(key_n);
    sw_hist.push_front(sw);
    synced_key = key_hist[2];
    prev_key   = key_hist[3];

    // Expected read is taken from pre-edge model state
    rd_known = 1'b1;
    exp_rd   = 16'h0;
    if (int'(a) < RAM_WORDS) begin
      if (m_mem.exists(int'(a))) exp_rd = m_mem[int'(a)];
      else rd_known = 1'b0;
    end else if (a == 15'h4000) exp_rd = m_led;
    else if (a == 15'h4001) exp_rd = m_hex;
    else if (a == 15'h6000) exp_rd = 16'(sw_hist[2]);
    else if (a == 15'h6001) exp_rd = {14'd0, ~synced_key, m_flag};
    exp_bad = (w | r) & ~is_mapped(a);

    if (w && int'(a) < RAM_WORDS) m_mem[int'(a)] = d;
    if (w && a == 15'h4000) m_led = d & c_LED_MASK;
    if (w && a == 15'h4001) m_hex = d;
    if (prev_key && !synced_key) m_flag = 1'b1;
    else if (r && a == 15'h6001) m_flag = 1'b0;

    void'(key_hist.pop_back());
    void'(sw_hist.pop_back());

    drive(a, d, w, r);
    tick();
    if (rd_known) check("rnd_rdata", rdata, exp_rd);
    check("rnd_bad", 16'(bad_addr), 16'(exp_bad));
    check("rnd_ledr", 16'(ledr), m_led);
    check("rnd_hex", hex_val, m_hex);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    nrst  = 1'b0;
    sw    = 10'h0;
    key_n = 1'b1;
    drive(15'h0, 16'h0, 1'b0, 1'b0);

    //             addr      wdata    we    re    chk   exp_rd   bad   led     hex
    vecs[0]  = '{15'h0005, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000, 16'h0000};
    vecs[1]  = '{15'h0005, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 10'h000, 16'h0000};
    vecs[2]  = '{15'h4000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h3FF, 16'h0000};
    vecs[3]  = '{15'h4000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h03FF, 1'b0, 10'h3FF, 16'h0000};
    vecs[4]  = '{15'h4001, 16'h0A1F, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h3FF, 16'h0A1F};
    vecs[5]  = '{15'h4001, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0A1F, 1'b0, 10'h3FF, 16'h1234};
    vecs[6]  = '{15'h4001, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 10'h3FF, 16'h1234};
    vecs[7]  = '{15'h7000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h3FF, 16'h1234};
    vecs[8]  = '{15'h7000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h3FF, 16'h1234};
    vecs[9]  = '{15'h5000, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 10'h3FF, 16'h1234};
    vecs[10] = '{15'h6000, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h3FF, 16'h1234};
    vecs[11] = '{15'h6001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h3FF, 16'h1234};
    vecs[12] = '{15'h3FFF, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h3FF, 16'h1234};
    vecs[13] = '{15'h3FFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 10'h3FF, 16'h1234};
    vecs[14] = '{15'h4002, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h3FF, 16'h1234};
    vecs[15] = '{15'h0005, 16'h0F0F, 1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, 10'h3FF, 16'h1234};
    vecs[16] = '{15'h0005, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0F0F, 1'b0, 10'h3FF, 16'h1234};
    vecs[17] = '{15'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h03FF, 1'b0, 10'h3FF, 16'h1234};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      tick();
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_bad", i), 16'(bad_addr), 16'(vecs[i].exp_bad));
      check($sformatf("vec%0d_ledr", i), 16'(ledr), 16'(vecs[i].exp_led));
      check($sformatf("vec%0d_hex", i), hex_val, vecs[i].exp_hex);
    end

    // Switch synchronizer latency, then an ignored write to the status word
    sw = 10'h2A5;
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) tick();
    drive(15'h6000, 16'h0, 1'b0, 1'b1);
    tick();
    check("sw_read", rdata, 16'h02A5);
    drive(15'h6000, 16'h1234, 1'b1, 1'b0);
    tick();
    check("sw_write_bad", 16'(bad_addr), 16'h0);
    drive(15'h6000, 16'h0, 1'b0, 1'b1);
    tick();
    check("sw_after_write", rdata, 16'h02A5);
    sw = 10'h0;

    // Key press held for 5 cycles, read while level still pressed
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    key_n = 1'b0;
    repeat (5) tick();
    key_n = 1'b1;
    drive(15'h6001, 16'h0, 1'b0, 1'b1);
    tick();
    check("key_evt_read", rdata, 16'h0003);
    tick();
    check("key_evt_cleared", rdata, 16'h0002);
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) tick();
    drive(15'h6001, 16'h0, 1'b0, 1'b1);
    tick();
    check("key_idle", rdata, 16'h0000);

    // Press edge coincident with a clearing read: set wins
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    key_n = 1'b0;
    repeat (2) tick();
    drive(15'h6001, 16'h0, 1'b0, 1'b1);
    tick();
    check("key_race_read", rdata, 16'h0002);
    tick();
    check("key_race_next", rdata, 16'h0003);
    tick();
    check("key_race_clear", rdata, 16'h0002);
    key_n = 1'b1;
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    repeat (4) tick();

    // Asynchronous reset mid-cycle: outputs clear without a clock edge
    check("pre_async_ledr", 16'(ledr), 16'h03FF);
    drive(15'h4000, 16'h0155, 1'b1, 1'b0);
    @(posedge CPUclk);
    #2;
    check("pre_async_ledr2", 16'(ledr), 16'h0155);
    drive(15'h4000, 16'h00AA, 1'b1, 1'b0);
    nrst = 1'b0;
    #1;
    check("async_ledr", 16'(ledr), 16'h0);
    check("async_hex", hex_val, 16'h0);
    check("async_rdata", rdata, 16'h0);
    tick();
    check("async_write_dropped", 16'(ledr), 16'h0);
    do_reset();

`ifdef HACK_HEX_DECODE_EN
    check("hex0_rst", 16'(hex0), 16'h00FF);
    check("hex1_rst", 16'(hex1), 16'h00FF);
    check("hex2_rst", 16'(hex2), 16'h00FF);
    check("hex3_rst", 16'(hex3), 16'h00FF);
    drive(15'h4001, 16'h0A1F, 1'b1, 1'b0);
    tick();
    drive(15'h0, 16'h0, 1'b0, 1'b0);
    tick();
    check("hex0_F", 16'(hex0), 16'h008E);
    check("hex1_1", 16'(hex1), 16'h00F9);
    check("hex2_A", 16'(hex2), 16'h0088);
    check("hex3_0", 16'(hex3), 16'h00C0);
    do_reset();
`endif

    // Randomized traffic against the behavioural model
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      random_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
